// File: rtl/joy_serial_scan.sv
`default_nettype none
// ============================================================================
// Module   : joy_serial_scan
// Purpose  : Scans a shift-register joystick adapter (LOAD/CLK out, DATA in)
//            for PLAYERS x BITS buttons, with a programmable bus rate, an
//            inter-scan gap, per-bit frame debounce, an enable/abort control
//            and a frame-complete strobe. Outputs are active-high.
// Ports    : clk        - core clock
//            Reset_I    - asynchronous active-low reset
//            enable     - 1 = scanning, 0 = bus idle and outputs cleared
//            JOY_DATA   - serial data from adapter (active-low buttons)
//            JOY_LOAD   - parallel-load strobe to adapter (active-low)
//            JOY_CLK    - shift clock to adapter
//            joystick   - debounced buttons, player p at [p*BITS +: BITS]
//            frame_stb  - one-clk pulse when a frame has been committed
// Revision : 1.0 - initial release
// ============================================================================
module joy_serial_scan #(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 12,
    parameter int CLK_DIV  = 4,
    parameter int SCAN_GAP = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic                    clk,
    input  logic                    Reset_I,
    input  logic                    enable,
    input  logic                    JOY_DATA,
    output logic                    JOY_LOAD,
    output logic                    JOY_CLK,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame_stb
);

    localparam int c_N     = PLAYERS * BITS;
    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_GAP_W = $clog2(SCAN_GAP + 1);
    localparam int c_BIT_W = $clog2(c_N + 1);
    localparam int c_DEB_W = $clog2(DEBOUNCE + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(SCAN_GAP - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_N - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LOAD   = 3'd1;
    localparam logic [2:0] c_S_LATCH  = 3'd2;
    localparam logic [2:0] c_S_CLK_HI = 3'd3;
    localparam logic [2:0] c_S_CLK_LO = 3'd4;
    localparam logic [2:0] c_S_DONE   = 3'd5;

    logic [c_DIV_W-1:0]              div_q,   div_d;
    logic [c_GAP_W-1:0]              gap_q,   gap_d;
    logic [c_BIT_W-1:0]              bit_q,   bit_d;
    logic [2:0]                      state_q, state_d;
    logic [1:0]                      sync_q;
    logic [c_N-1:0]                  raw_q,   raw_d;
    logic [c_N-1:0]                  joy_q,   joy_d;
    logic [c_N-1:0][c_DEB_W-1:0]     cnt_q,   cnt_d;
    logic                            load_q;
    logic                            sclk_q;
    logic                            stb_q,   stb_d;

    logic tick;
    logic commit;
    logic bit_in;

    // Divider is held at zero while disabled so a re-enabled scan always
    // starts on a fresh tick boundary (deterministic first-LOAD latency).
    assign tick   = (div_q == c_DIV_LAST);
    assign commit = enable && tick && (state_q == c_S_DONE);
    assign bit_in = ~sync_q[1];

    always_comb begin
        div_d = div_q;
        if (!enable || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + c_DIV_W'(1);
        end
    end

    // Scan sequencer: every transition waits for a tick.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        raw_d   = raw_q;
        if (!enable) begin
            state_d = c_S_IDLE;
            gap_d   = '0;
            bit_d   = '0;
        end else if (tick) begin
            case (state_q)
                c_S_IDLE: begin
                    bit_d = '0;
                    if (gap_q == c_GAP_LAST) begin
                        gap_d   = '0;
                        state_d = c_S_LOAD;
                    end else begin
                        gap_d = gap_q + c_GAP_W'(1);
                    end
                end
                c_S_LOAD: begin
                    state_d = c_S_LATCH;
                end
                c_S_LATCH: begin
                    raw_d[0] = bit_in;
                    bit_d    = c_BIT_W'(1);
                    state_d  = (c_N == 1) ? c_S_DONE : c_S_CLK_HI;
                end
                c_S_CLK_HI: begin
                    state_d = c_S_CLK_LO;
                end
                c_S_CLK_LO: begin
                    // Decoded write keeps the index width independent of N.
                    for (int i = 0; i < c_N; i++) begin
                        if (bit_q == c_BIT_W'(i)) begin
                            raw_d[i] = bit_in;
                        end
                    end
                    bit_d   = bit_q + c_BIT_W'(1);
                    state_d = (bit_q == c_BIT_LAST) ? c_S_DONE : c_S_CLK_HI;
                end
                c_S_DONE: begin
                    state_d = c_S_IDLE;
                end
                default: begin
                    state_d = c_S_IDLE;
                end
            endcase
        end
    end

    // Per-bit debounce: a bit flips only after DEBOUNCE consecutive frames
    // disagree with the current output; any agreeing frame restarts the run.
    always_comb begin
        joy_d = joy_q;
        cnt_d = cnt_q;
        stb_d = commit;
        if (!enable) begin
            joy_d = '0;
            cnt_d = '0;
        end else if (commit) begin
            for (int i = 0; i < c_N; i++) begin
                if (raw_q[i] == joy_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == c_DEB_LAST) begin
                    joy_d[i] = raw_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + c_DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_I) begin
        if (!Reset_I) begin
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            state_q <= c_S_IDLE;
            sync_q  <= 2'b11;
            raw_q   <= '0;
            joy_q   <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b1;
            sclk_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            state_q <= state_d;
            sync_q  <= {sync_q[0], JOY_DATA};
            raw_q   <= raw_d;
            joy_q   <= joy_d;
            cnt_q   <= cnt_d;
            // Bus pins are decoded from the next state so they change on
            // the same edge as the state they belong to.
            load_q  <= (state_d != c_S_LOAD);
            sclk_q  <= (state_d == c_S_CLK_HI);
            stb_q   <= stb_d;
        end
    end

    assign JOY_LOAD  = load_q;
    assign JOY_CLK   = sclk_q;
    assign joystick  = joy_q;
    assign frame_stb = stb_q;

endmodule
`default_nettype wire
